// File: rtl/dmem_bus_arbiter_if.sv
// Bus bundle between the CPU/DMA requesters, the arbiter and the data memory/IO decode.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface dmem_bus_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_rdata;

  logic        dma_req;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_gnt;
  logic        dma_err;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;

  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata;

  logic        starve_clr;
  logic        starved;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata, starve_clr,
    output cpu_rdata, dma_gnt, dma_err, dma_rdata, dma_rvalid,
    output mem_addr, mem_wdata, mem_we, mem_re, starved
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata, starve_clr,
    input  cpu_rdata, dma_gnt, dma_err, dma_rdata, dma_rvalid,
    input  mem_addr, mem_wdata, mem_we, mem_re, starved
  );
endinterface

// File: rtl/dmem_bus_arbiter.sv
// CPU-priority arbiter for the data memory/IO bus with one DMA requester.
// Tracks DMA read-data ownership over the 1-cycle read latency and flags DMA starvation.
module dmem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 255,
  parameter logic [15:0] IO_BASE      = 16'h1000
) (
  input logic               clk,
  input logic               reset,
  dmem_bus_arbiter_if.slave bus
);

  localparam logic [7:0] Limit = 8'(STARVE_LIMIT);

  logic       cpu_busy, dma_go, io_hit, dma_ok, dma_rvalid;
  logic       rd_owner_d, rd_owner_q;
  logic [7:0] wait_cnt_d, wait_cnt_q;
  logic       starved_d, starved_q;
  logic [7:0] dma_rdata_d, dma_rdata_q;

  assign cpu_busy   = bus.cpu_we | bus.cpu_re;
  assign dma_go     = bus.dma_req & ~cpu_busy & ~reset;
  assign io_hit     = bus.dma_addr[15:8] == IO_BASE[15:8];
  assign dma_ok     = dma_go & ~io_hit;
  // A read owned by DMA is dropped if reset lands on its return cycle.
  assign dma_rvalid = rd_owner_q & ~reset;

  always_comb begin
    bus.mem_addr  = bus.cpu_addr;
    bus.mem_wdata = bus.cpu_wdata;
    bus.mem_we    = 1'b0;
    bus.mem_re    = 1'b0;
    if (cpu_busy) begin
      bus.mem_we = bus.cpu_we;
      bus.mem_re = bus.cpu_re;
    end else if (dma_ok) begin
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
      bus.mem_we    = bus.dma_we;
      bus.mem_re    = ~bus.dma_we;
    end
  end

  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.dma_gnt    = dma_go;
  assign bus.dma_err    = dma_go & io_hit;
  assign bus.dma_rvalid = dma_rvalid;
  assign bus.dma_rdata  = dma_rvalid ? bus.mem_rdata : dma_rdata_q;
  assign bus.starved    = starved_q;

  always_comb begin
    rd_owner_d  = dma_ok & ~bus.dma_we;
    dma_rdata_d = dma_rvalid ? bus.mem_rdata : dma_rdata_q;
    wait_cnt_d  = 8'd0;
    if (bus.dma_req && !dma_go) begin
      wait_cnt_d = (wait_cnt_q >= Limit) ? Limit : wait_cnt_q + 8'd1;
    end
    // Set has priority over a simultaneous clear.
    if (wait_cnt_d == Limit) begin
      starved_d = 1'b1;
    end else if (bus.starve_clr) begin
      starved_d = 1'b0;
    end else begin
      starved_d = starved_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q  <= 1'b0;
      wait_cnt_q  <= 8'd0;
      starved_q   <= 1'b0;
      dma_rdata_q <= 8'd0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      wait_cnt_q  <= wait_cnt_d;
      starved_q   <= starved_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_bus_arbiter.sv
// Self-checking bench for dmem_bus_arbiter: combinational vector table plus multi-cycle sequences,
// with DMA read data tracked through a scoreboard queue.
module tb_dmem_bus_arbiter;

  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [7:0] exp_q[$];

  dmem_bus_arbiter_if bus ();

  dmem_bus_arbiter #(
    .STARVE_LIMIT(4),
    .IO_BASE     (16'h1000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_we;
    logic        cpu_re;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wdata;
    logic [7:0]  mem_rdata;
    logic [15:0] x_addr;
    logic [7:0]  x_wdata;
    logic        x_we;
    logic        x_re;
    logic        x_gnt;
    logic        x_err;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_addr   = 16'h0000;
    bus.cpu_wdata  = 8'h00;
    bus.cpu_we     = 1'b0;
    bus.cpu_re     = 1'b0;
    bus.dma_req    = 1'b0;
    bus.dma_we     = 1'b0;
    bus.dma_addr   = 16'h0000;
    bus.dma_wdata  = 8'h00;
    bus.mem_rdata  = 8'h00;
    bus.starve_clr = 1'b0;
  endtask

  task automatic dma(input logic we, input logic [15:0] addr, input logic [7:0] wdata);
    bus.dma_req   = 1'b1;
    bus.dma_we    = we;
    bus.dma_addr  = addr;
    bus.dma_wdata = wdata;
  endtask

  // Scoreboard consumer: every DMA read return must match the oldest expected value.
  always @(negedge clk) begin
    if (bus.dma_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", 16'(bus.dma_rvalid), 16'h0);
      end else begin
        chk("sb_dma_rdata", 16'(bus.dma_rdata), 16'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    vecs[0] = '{16'h0020, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h5A,
                16'h0020, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h0300, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0040, 8'hA5, 8'h00,
                16'h0040, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h0300, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 16'h1005, 8'h33, 8'h00,
                16'h0300, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3] = '{16'h0200, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 16'h0060, 8'h44, 8'hC3,
                16'h0200, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h0400, 8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0040, 8'hA5, 8'h00,
                16'h0400, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{16'h0300, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 16'h10FF, 8'h99, 8'h00,
                16'h0300, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[6] = '{16'h0300, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0FFF, 8'h66, 8'h00,
                16'h0FFF, 8'h66, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{16'h0300, 8'h11, 1'b0, 1'b0, 1'b1, 1'b1, 16'h1100, 8'h67, 8'h00,
                16'h1100, 8'h67, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{16'h0210, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0040, 8'hA5, 8'h81,
                16'h0210, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};

    // Reset: DMA held off, CPU pass-through still live.
    idle_inputs();
    reset       = 1'b1;
    bus.cpu_re  = 1'b1;
    bus.cpu_addr = 16'h0020;
    next_cycle();
    bus.cpu_re  = 1'b0;
    dma(1'b1, 16'h0040, 8'hA5);
    @(negedge clk);
    chk("rst_dma_gnt", 16'(bus.dma_gnt), 16'h0);
    chk("rst_dma_err", 16'(bus.dma_err), 16'h0);
    chk("rst_mem_we", 16'(bus.mem_we), 16'h0);
    chk("rst_starved", 16'(bus.starved), 16'h0);
    chk("rst_dma_rdata", 16'(bus.dma_rdata), 16'h0);
    chk("rst_dma_rvalid", 16'(bus.dma_rvalid), 16'h0);
    bus.dma_req  = 1'b0;
    bus.cpu_re   = 1'b1;
    #1;
    chk("rst_cpu_mem_re", 16'(bus.mem_re), 16'h1);
    chk("rst_cpu_mem_addr", bus.mem_addr, 16'h0020);
    next_cycle();
    reset = 1'b0;
    idle_inputs();

    // Combinational vector table.
    for (int i = 0; i < 9; i++) begin
      bus.cpu_addr  = vecs[i].cpu_addr;
      bus.cpu_wdata = vecs[i].cpu_wdata;
      bus.cpu_we    = vecs[i].cpu_we;
      bus.cpu_re    = vecs[i].cpu_re;
      bus.dma_req   = vecs[i].dma_req;
      bus.dma_we    = vecs[i].dma_we;
      bus.dma_addr  = vecs[i].dma_addr;
      bus.dma_wdata = vecs[i].dma_wdata;
      bus.mem_rdata = vecs[i].mem_rdata;
      @(negedge clk);
      chk($sformatf("v%0d_mem_addr", i), bus.mem_addr, vecs[i].x_addr);
      chk($sformatf("v%0d_mem_wdata", i), 16'(bus.mem_wdata), 16'(vecs[i].x_wdata));
      chk($sformatf("v%0d_mem_we", i), 16'(bus.mem_we), 16'(vecs[i].x_we));
      chk($sformatf("v%0d_mem_re", i), 16'(bus.mem_re), 16'(vecs[i].x_re));
      chk($sformatf("v%0d_dma_gnt", i), 16'(bus.dma_gnt), 16'(vecs[i].x_gnt));
      chk($sformatf("v%0d_dma_err", i), 16'(bus.dma_err), 16'(vecs[i].x_err));
      chk($sformatf("v%0d_cpu_rdata", i), 16'(bus.cpu_rdata), 16'(vecs[i].mem_rdata));
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // DMA read with return data held afterwards.
    dma(1'b0, 16'h0041, 8'h00);
    @(negedge clk);
    chk("rd_gnt", 16'(bus.dma_gnt), 16'h1);
    chk("rd_mem_re", 16'(bus.mem_re), 16'h1);
    chk("rd_mem_addr", bus.mem_addr, 16'h0041);
    exp_q.push_back(8'h3C);
    next_cycle();
    idle_inputs();
    bus.mem_rdata = 8'h3C;
    @(negedge clk);
    chk("rd_rvalid", 16'(bus.dma_rvalid), 16'h1);
    next_cycle();
    bus.mem_rdata = 8'hFF;
    @(negedge clk);
    chk("rd_rvalid_pulse", 16'(bus.dma_rvalid), 16'h0);
    chk("rd_hold", 16'(bus.dma_rdata), 16'h003C);
    next_cycle();

    // Back-to-back read, write, read.
    dma(1'b0, 16'h0050, 8'h00);
    exp_q.push_back(8'h11);
    next_cycle();
    dma(1'b1, 16'h0051, 8'hB7);
    bus.mem_rdata = 8'h11;
    @(negedge clk);
    chk("b2b_wr_gnt", 16'(bus.dma_gnt), 16'h1);
    chk("b2b_wr_we", 16'(bus.mem_we), 16'h1);
    next_cycle();
    dma(1'b0, 16'h0052, 8'h00);
    bus.mem_rdata = 8'h00;
    @(negedge clk);
    chk("b2b_rd_gnt", 16'(bus.dma_gnt), 16'h1);
    exp_q.push_back(8'h22);
    next_cycle();
    idle_inputs();
    bus.mem_rdata = 8'h22;
    next_cycle();
    bus.mem_rdata = 8'h00;
    @(negedge clk);
    chk("b2b_hold", 16'(bus.dma_rdata), 16'h0022);
    next_cycle();

    // CPU write for 3 cycles while DMA waits; grant on the 4th.
    dma(1'b1, 16'h0060, 8'h44);
    for (int c = 0; c < 4; c++) begin
      bus.cpu_we    = (c < 3);
      bus.cpu_addr  = 16'h0200;
      bus.cpu_wdata = 8'h77;
      @(negedge clk);
      chk($sformatf("cont%0d_gnt", c), 16'(bus.dma_gnt), (c == 3) ? 16'h1 : 16'h0);
      chk($sformatf("cont%0d_addr", c), bus.mem_addr, (c == 3) ? 16'h0060 : 16'h0200);
      chk($sformatf("cont%0d_wdata", c), 16'(bus.mem_wdata), (c == 3) ? 16'h44 : 16'h77);
      next_cycle();
    end
    idle_inputs();
    @(negedge clk);
    chk("cont_not_starved", 16'(bus.starved), 16'h0);
    next_cycle();

    // Starvation: 6 CPU reads with a waiting DMA read, clear held during saturation.
    dma(1'b0, 16'h0070, 8'h00);
    bus.cpu_re = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.starve_clr = (c == 5);
      @(negedge clk);
      chk($sformatf("stv%0d_starved", c), 16'(bus.starved), (c >= 4) ? 16'h1 : 16'h0);
      chk($sformatf("stv%0d_gnt", c), 16'(bus.dma_gnt), 16'h0);
      next_cycle();
    end
    bus.cpu_re     = 1'b0;
    bus.starve_clr = 1'b0;
    @(negedge clk);
    chk("stv_grant", 16'(bus.dma_gnt), 16'h1);
    chk("stv_set_wins", 16'(bus.starved), 16'h1);
    exp_q.push_back(8'h9D);
    next_cycle();
    idle_inputs();
    bus.mem_rdata  = 8'h9D;
    bus.starve_clr = 1'b1;
    @(negedge clk);
    chk("stv_clr_same_cycle", 16'(bus.starved), 16'h1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("stv_cleared", 16'(bus.starved), 16'h0);
    chk("stv_rdata_hold", 16'(bus.dma_rdata), 16'h009D);
    next_cycle();

    // Reset on the return cycle of a DMA read drops the data.
    dma(1'b0, 16'h0080, 8'h00);
    next_cycle();
    idle_inputs();
    reset         = 1'b1;
    bus.mem_rdata = 8'hEE;
    @(negedge clk);
    chk("rstrd_rvalid", 16'(bus.dma_rvalid), 16'h0);
    next_cycle();
    reset = 1'b0;
    bus.mem_rdata = 8'h00;
    @(negedge clk);
    chk("rstrd_rdata", 16'(bus.dma_rdata), 16'h0);
    chk("rstrd_rvalid_after", 16'(bus.dma_rvalid), 16'h0);
    next_cycle();

    chk("sb_drained", 16'(exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
